// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with a multi-cycle shift engine.
//
// Commands are launched by a start strobe accepted only in IDLE. NOP, LOAD
// and CLEAR complete on the accepting edge. Shift ops (SHL, SHR, ASR, ROL,
// ROR) move one bit per edge, the first bit on the accepting edge, for
// N = min(amt, WIDTH) steps, and pulse done on the edge of the last step.
//
// Handshake: start is a one-cycle command strobe. It is sampled on an edge
// only while busy=0; while busy=1 start, op, amt and d are ignored.
// done pulses for exactly one cycle per accepted command. A start present in
// the cycle where done=1 is accepted (back-to-back commands).
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   reset   : synchronous active-high reset, dominates everything
//   start   : command strobe
//   op      : 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ASR, 101 ROL,
//             110 ROR, 111 CLEAR
//   amt     : shift amount (saturates to WIDTH)
//   d       : parallel load data
//   sin     : serial fill bit for SHL/SHR, sampled on every step
//   q       : register contents
//   sout    : last bit shifted out
//   busy    : multi-cycle shift in progress
//   done    : one-cycle completion pulse
//   state_o : FSM state for observation (0 IDLE, 1 SHIFT)
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             state_o
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ASR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] reg_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;

  logic [2:0]       step_op;
  logic [CNT_W-1:0] n_eff;
  logic [WIDTH-1:0] reg_d;
  logic             sout_d;

  // Saturated shift amount for the command being accepted.
  always_comb begin
    n_eff = amt;
    if (amt > CNT_W'(WIDTH)) n_eff = CNT_W'(WIDTH);
  end

  // The accepting edge performs the first step with the incoming op; later
  // steps use the op latched at acceptance.
  assign step_op = (state_q == IDLE) ? op : op_q;

  // One shift step of the current register value.
  always_comb begin
    reg_d  = reg_q;
    sout_d = sout_q;
    case (step_op)
      OP_SHL: begin
        reg_d  = {reg_q[WIDTH-2:0], sin};
        sout_d = reg_q[WIDTH-1];
      end
      OP_SHR: begin
        reg_d  = {sin, reg_q[WIDTH-1:1]};
        sout_d = reg_q[0];
      end
      OP_ASR: begin
        reg_d  = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
        sout_d = reg_q[0];
      end
      OP_ROL: begin
        reg_d  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        sout_d = reg_q[WIDTH-1];
      end
      OP_ROR: begin
        reg_d  = {reg_q[0], reg_q[WIDTH-1:1]};
        sout_d = reg_q[0];
      end
      default: begin
        reg_d  = reg_q;
        sout_d = sout_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_NOP:   done_q <= 1'b1;
              OP_LOAD: begin
                reg_q  <= d;
                done_q <= 1'b1;
              end
              OP_CLEAR: begin
                reg_q  <= '0;
                done_q <= 1'b1;
              end
              default: begin
                if (n_eff == '0) begin
                  done_q <= 1'b1;
                end else begin
                  reg_q  <= reg_d;
                  sout_q <= sout_d;
                  if (n_eff == CNT_W'(1)) begin
                    done_q <= 1'b1;
                  end else begin
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                    cnt_q   <= n_eff - CNT_W'(1);
                    op_q    <= op;
                  end
                end
              end
            endcase
          end
        end
        SHIFT: begin
          reg_q  <= reg_d;
          sout_q <= sout_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          // cnt_q counts steps still to do including this one.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q       = reg_q;
  assign sout    = sout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;
  logic       state_o;

  int checks = 0;
  int failures = 0;

  // Expected {sout, q} at each done pulse.
  logic [W:0] exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       sin;
    logic [7:0] eq;
    logic       es;
    int         lat;
  } vec_t;

  vec_t tbl[12];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .d(d),
    .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done), .state_o(state_o)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Pop the scoreboard at a done pulse and compare.
  task automatic score(input string name);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_q"}, q, e[W-1:0]);
      check({name, "_sout"}, sout, e[W]);
    end
  endtask

  // Drive one command, wait for done (bounded), check latency/busy/result,
  // then check done drops and q holds. inject>0 pulses start=CLEAR mid-shift.
  task automatic do_cmd(input string name, input logic [2:0] o, input logic [3:0] a,
                        input logic [7:0] dd, input logic s, input logic [7:0] eq,
                        input logic es, input int lat_exp, input int inject);
    int lat;
    logic [7:0] q_hold;
    @(negedge clk);
    start = 1'b1; op = o; amt = a; d = dd; sin = s;
    exp_q.push_back({es, eq});
    @(posedge clk); #1;
    lat = 1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); amt = 4'($urandom_range(0, 15));
    d = 8'($urandom_range(0, 255));
    while (!done && lat < 40) begin
      check({name, "_busy"}, busy, 1);
      if (lat == inject) begin
        start = 1'b1; op = 3'b111;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      check({name, "_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      check({name, "_latency"}, lat, lat_exp);
      check({name, "_busy_at_done"}, busy, 0);
      score(name);
    end
    q_hold = q;
    @(posedge clk); #1;
    check({name, "_done_drop"}, done, 0);
    check({name, "_hold"}, q, q_hold);
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; amt = '0; d = '0; sin = 1'b0;
    tbl[0]  = '{3'b001, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1}; // LOAD
    tbl[1]  = '{3'b010, 4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 3}; // SHL 3, sin=1
    tbl[2]  = '{3'b001, 4'd0,  8'h90, 1'b0, 8'h90, 1'b1, 1}; // LOAD keeps sout
    tbl[3]  = '{3'b100, 4'd2,  8'h00, 1'b1, 8'hE4, 1'b0, 2}; // ASR 2
    tbl[4]  = '{3'b011, 4'd1,  8'hFF, 1'b0, 8'h72, 1'b0, 1}; // SHR 1
    tbl[5]  = '{3'b000, 4'd5,  8'hFF, 1'b1, 8'h72, 1'b0, 1}; // NOP
    tbl[6]  = '{3'b101, 4'd0,  8'hFF, 1'b1, 8'h72, 1'b0, 1}; // ROL 0
    tbl[7]  = '{3'b101, 4'd4,  8'h00, 1'b0, 8'h27, 1'b1, 4}; // ROL 4
    tbl[8]  = '{3'b011, 4'd15, 8'h00, 1'b1, 8'hFF, 1'b0, 8}; // SHR sat 8
    tbl[9]  = '{3'b110, 4'd1,  8'h00, 1'b0, 8'hFF, 1'b1, 1}; // ROR 1
    tbl[10] = '{3'b111, 4'd3,  8'h55, 1'b0, 8'h00, 1'b1, 1}; // CLEAR keeps sout
    tbl[11] = '{3'b001, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b1, 1}; // LOAD 3C

    // Reset for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 8'h00);
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_o, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 12; i++)
      do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].sin,
             tbl[i].eq, tbl[i].es, tbl[i].lat, 0);

    // ROR saturated at 8 steps with a CLEAR start pulsed mid-shift.
    do_cmd("ror_sat", 3'b110, 4'd12, 8'h00, 1'b0, 8'h3C, 1'b0, 8, 4);

    // Back-to-back: start held through the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; op = 3'b001; d = 8'h11; exp_q.push_back({1'b0, 8'h11});
    @(posedge clk); #1;
    check("b2b_done1", done, 1);
    if (done) score("b2b_load");
    op = 3'b101; amt = 4'd1; exp_q.push_back({1'b0, 8'h22});
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done2", done, 1);
    if (done) score("b2b_rol");

    // Reset abort of ROL 5 after two steps.
    do_cmd("load81", 3'b001, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1, 0);
    @(negedge clk);
    start = 1'b1; op = 3'b101; amt = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_step1_q", q, 8'h03);
    @(posedge clk); #1;
    check("abort_step2_q", q, 8'h06);
    check("abort_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_q", q, 8'h00);
    check("abort_busy_clr", busy, 0);
    check("abort_sout", sout, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end

    // First start after reset accepted normally.
    do_cmd("post_rst", 3'b001, 4'd0, 8'h5A, 1'b1, 8'h5A, 1'b0, 1, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have derived localparam CNT_W, equal to $clog2(WIDTH+1), giving the shift-amount and counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: command strobe, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3 bits: operation code, with values 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ASR, 101 ROL, 110 ROR, 111 CLEAR.
REQ-007 The block SHALL have port amt, input, CNT_W bits: shift amount, sampled with start.
REQ-008 The block SHALL have port d, input, WIDTH bits: parallel load data, sampled with start.
REQ-009 The block SHALL have port sin, input, 1 bit: serial fill bit for SHL/SHR, sampled on every shift step.
REQ-010 The block SHALL have port q, output reg, WIDTH bits: register contents.
REQ-011 The block SHALL have port sout, output reg, 1 bit: the last bit shifted out.
REQ-012 The block SHALL have port busy, output reg, 1 bit: a multi-cycle shift is in progress.
REQ-013 The block SHALL have port done, output reg, 1 bit: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE and SHIFT; only start accepted in IDLE launches a command.
REQ-015 In IDLE with start=1 and op in {NOP, LOAD, CLEAR}, the accepting edge SHALL set q=q, q=d or q=0 respectively, and SHALL set done=1; busy SHALL stay 0.
REQ-016 Shift ops (SHL, SHR, ASR, ROL, ROR) SHALL move exactly one bit per edge; the first step SHALL occur on the accepting edge.
REQ-017 The effective shift amount N SHALL be min(amt, WIDTH); amt > WIDTH SHALL saturate to WIDTH.
REQ-018 When N=0, the accepting edge SHALL leave q and sout unchanged and set done=1.
REQ-019 When N=1, the op SHALL complete in one edge: done=1, busy=0.
REQ-020 When N≥2, the accepting edge SHALL enter SHIFT with busy=1 and the remaining counter = N-1; each further edge SHALL shift once and decrement the counter.
REQ-021 The edge performing the final (Nth) step SHALL return the FSM to IDLE, clear busy and set done=1.
REQ-022 Total latency SHALL be max(N,1) edges from acceptance to done.
REQ-023 The shift steps SHALL behave as follows:
- SHL: q <= {q[W-2:0], sin}, sout <= q[W-1].
- SHR: q <= {sin, q[W-1:1]}, sout <= q[0].
- ASR: q <= {q[W-1], q[W-1:1]}, sout <= q[0].
- ROL: q <= {q[W-2:0], q[W-1]}, sout <= q[W-1].
- ROR: q <= {q[0], q[W-1:1]}, sout <= q[0].
REQ-024 NOP, LOAD and CLEAR SHALL leave sout unchanged.
REQ-025 While busy=1, start, op, amt and d SHALL be ignored; op and N SHALL be latched at acceptance.
REQ-026 done SHALL be high for exactly one cycle per accepted command and SHALL be 0 in all other cycles.
REQ-027 A new start in the cycle where done=1 (FSM in IDLE) SHALL be accepted, allowing back-to-back commands.
REQ-028 When reset=0, q and sout SHALL hold their values whenever the block is idle and start=0.

Reset
REQ-029 On any clk edge with reset=1, the block SHALL set q=0, sout=0, busy=0, done=0, FSM=IDLE and counter=0.
REQ-030 reset SHALL dominate start and any in-progress shift; an aborted command SHALL never produce done.
REQ-031 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-032 Reset scenario: reset=1 for 2 edges -> q=8'h00, sout=0, busy=0, done=0.
REQ-033 LOAD scenario: LOAD with d=8'hA5 -> after 1 edge, q=8'hA5 and done=1 for one cycle.
REQ-034 SHL scenario: from q=8'hA5, SHL with amt=3 and sin=1 -> intermediate q values 4B and 97, final q=8'h2F, sout=1; busy=1 for 2 cycles, done on the 3rd edge.
REQ-035 ASR scenario: from q=8'h90, ASR with amt=2 -> q=8'hE4, sout=0.
REQ-036 ROR saturation scenario: from q=8'h3C, ROR with amt=12 -> 8 steps (saturated), final q=8'h3C, done on the 8th edge; a start with op=CLEAR pulsed mid-shift SHALL be ignored.
REQ-037 Reset-abort scenario: from q=8'h81, ROL with amt=5, reset after 2 steps -> q=8'h00, busy=0, no done pulse.
